// File: rtl/video_trans_eth_arp_tx_2.sv
// ---------------------------------------------------------------------------
// video_trans_eth_arp_tx_2
//
// ARP transmit stage on the GMII TX side of the video-over-Ethernet path.
// A single command (request or reply) produces one complete Ethernet II /
// ARP frame: 7x 0x55 preamble, 0xD5 SFD, 14-byte Ethernet header, 28-byte
// ARP body, 18 zero pad bytes and a 4-byte CRC32 FCS (72 bytes in total).
// The frame is followed by an inter-frame gap before a new command is
// accepted.
//
// Ports
//   clk          in   1   GMII TX clock, one byte per cycle
//   rst_n        in   1   asynchronous, active-low reset
//   arp_tx_en    in   1   start pulse, sampled only while busy=0
//   arp_tx_type  in   1   0 = ARP request (opcode 1), 1 = ARP reply (opcode 2)
//   des_mac      in   48  target MAC (reply only)
//   des_ip       in   32  target IP
//   busy         out  1   frame or inter-frame gap in progress
//   tx_done      out  1   one-cycle pulse in the cycle after the last FCS byte
//   gmii_tx_en   out  1   GMII transmit enable
//   gmii_txd     out  8   GMII transmit data
//
// Handshake: a command is taken in any cycle where arp_tx_en=1 and busy=0;
// arp_tx_type/des_mac/des_ip are captured in that same cycle and may change
// afterwards. While busy=1 arp_tx_en is ignored and nothing is queued.
// ---------------------------------------------------------------------------
module video_trans_eth_arp_tx_2 #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        busy,
    output logic        tx_done,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    typedef enum logic [6:0] {
        S_IDLE = 7'b000_0001,
        S_PRE  = 7'b000_0010,
        S_ETH  = 7'b000_0100,
        S_ARP  = 7'b000_1000,
        S_PAD  = 7'b001_0000,
        S_FCS  = 7'b010_0000,
        S_IFG  = 7'b100_0000
    } state_t;

    localparam logic [6:0] LP_IFG = 7'(IFG_BYTES);

    // Reflected CRC32 (poly 0xEDB88320), one byte per call, LSB first.
    function automatic logic [31:0] f_crc32_byte(input logic [31:0] crc,
                                                 input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [31:0] r_crc;
    logic        r_type;
    logic [47:0] r_des_mac;
    logic [31:0] r_des_ip;
    logic        r_busy;
    logic        r_tx_done;
    logic        r_tx_en;
    logic [7:0]  r_txd;

    logic [47:0]  w_dst_mac;
    logic [47:0]  w_tgt_mac;
    logic [15:0]  w_opcode;
    logic [111:0] w_eth_vec;
    logic [223:0] w_arp_vec;
    logic [6:0]   w_eth_idx;
    logic [6:0]   w_arp_idx;
    logic [111:0] w_eth_sh;
    logic [223:0] w_arp_sh;
    logic [31:0]  w_fcs;
    logic [31:0]  w_fcs_sh;
    logic [7:0]   w_byte;
    logic [31:0]  w_crc_next;

    assign w_dst_mac = r_type ? r_des_mac : 48'hFFFF_FFFF_FFFF;
    assign w_tgt_mac = r_type ? r_des_mac : 48'h0;
    assign w_opcode  = r_type ? 16'h0002 : 16'h0001;

    assign w_eth_vec = {w_dst_mac, BOARD_MAC, 16'h0806};
    assign w_arp_vec = {16'h0001, 16'h0800, 8'h06, 8'h04, w_opcode,
                        BOARD_MAC, BOARD_IP, w_tgt_mac, r_des_ip};

    // Byte r_cnt of a field vector, MSB byte first: shift it down to [7:0].
    assign w_eth_idx = 7'd13 - r_cnt;
    assign w_arp_idx = 7'd27 - r_cnt;
    assign w_eth_sh  = w_eth_vec >> {w_eth_idx, 3'b000};
    assign w_arp_sh  = w_arp_vec >> {w_arp_idx, 3'b000};

    // FCS goes out low byte first.
    assign w_fcs    = ~r_crc;
    assign w_fcs_sh = w_fcs >> {r_cnt[1:0], 3'b000};

    // Byte to load into gmii_txd at the next edge. In PRE the first 0x55 was
    // already sent on acceptance, so counts 0..6 cover bytes 1..7 (SFD last).
    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            S_PRE:   w_byte = (r_cnt == 7'd6) ? 8'hD5 : 8'h55;
            S_ETH:   w_byte = w_eth_sh[7:0];
            S_ARP:   w_byte = w_arp_sh[7:0];
            S_PAD:   w_byte = 8'h00;
            S_FCS:   w_byte = w_fcs_sh[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    assign w_crc_next = f_crc32_byte(r_crc, w_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 7'd0;
            r_crc     <= 32'hFFFF_FFFF;
            r_type    <= 1'b0;
            r_des_mac <= 48'h0;
            r_des_ip  <= 32'h0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_en   <= 1'b0;
            r_txd     <= 8'h00;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arp_tx_en) begin
                        r_type    <= arp_tx_type;
                        r_des_mac <= des_mac;
                        r_des_ip  <= des_ip;
                        r_state   <= S_PRE;
                        r_cnt     <= 7'd0;
                        r_busy    <= 1'b1;
                        r_tx_en   <= 1'b1;
                        r_txd     <= 8'h55;
                    end
                end
                S_PRE: begin
                    r_txd <= w_byte;
                    if (r_cnt == 7'd6) begin
                        r_state <= S_ETH;
                        r_cnt   <= 7'd0;
                        r_crc   <= 32'hFFFF_FFFF;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_ETH: begin
                    r_txd <= w_byte;
                    r_crc <= w_crc_next;
                    if (r_cnt == 7'd13) begin
                        r_state <= S_ARP;
                        r_cnt   <= 7'd0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_ARP: begin
                    r_txd <= w_byte;
                    r_crc <= w_crc_next;
                    if (r_cnt == 7'd27) begin
                        r_state <= S_PAD;
                        r_cnt   <= 7'd0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_PAD: begin
                    r_txd <= w_byte;
                    r_crc <= w_crc_next;
                    if (r_cnt == 7'd17) begin
                        r_state <= S_FCS;
                        r_cnt   <= 7'd0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_FCS: begin
                    r_txd <= w_byte;
                    if (r_cnt == 7'd3) begin
                        r_state <= S_IFG;
                        r_cnt   <= 7'd0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_IFG: begin
                    // Count 0 is the tx_done cycle; busy drops after
                    // IFG_BYTES cycles counted from there.
                    r_tx_en <= 1'b0;
                    r_txd   <= 8'h00;
                    if (r_cnt == 7'd0) r_tx_done <= 1'b1;
                    if (r_cnt == LP_IFG) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        r_cnt   <= 7'd0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 7'd0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign tx_done    = r_tx_done;
    assign gmii_tx_en = r_tx_en;
    assign gmii_txd   = r_txd;

endmodule

// File: tb/tb_video_trans_eth_arp_tx_2.sv
// Bench for video_trans_eth_arp_tx_2: expected frames are built from the
// field values and pushed into exp_q at command time; the monitor pops one
// byte per gmii_tx_en cycle and also checks frame length, tx_done placement,
// busy length after the frame and the inter-frame spacing.
module tb_video_trans_eth_arp_tx_2;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hC0A8_010A;
  localparam int          IFG_BYTES = 12;
  localparam logic [31:0] POLY      = 32'hEDB8_8320;

  logic        clk;
  logic        rst_n;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        busy;
  logic        tx_done;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;

  video_trans_eth_arp_tx_2 #(
    .BOARD_MAC(BOARD_MAC),
    .BOARD_IP (BOARD_IP),
    .IFG_BYTES(IFG_BYTES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arp_tx_en  (arp_tx_en),
    .arp_tx_type(arp_tx_type),
    .des_mac    (des_mac),
    .des_ip     (des_ip),
    .busy       (busy),
    .tx_done    (tx_done),
    .gmii_tx_en (gmii_tx_en),
    .gmii_txd   (gmii_txd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #4 clk = ~clk;

  // scoreboard state
  logic [7:0] exp_q[$];
  int n_checks;
  int n_fails;
  int done_cnt;
  int mon_run;
  bit b2b_mode;
  bit stim_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Builds the expected 72-byte frame with an independent CRC32 model.
  task automatic push_frame(input bit typ, input logic [47:0] mac, input logic [31:0] ip);
    logic [479:0] v;
    logic [47:0]  dmac;
    logic [47:0]  tmac;
    logic [15:0]  op;
    logic [31:0]  crc;
    logic [31:0]  fcs;
    logic [7:0]   b;
    dmac = typ ? mac : 48'hFFFF_FFFF_FFFF;
    tmac = typ ? mac : 48'h0;
    op   = typ ? 16'h0002 : 16'h0001;
    v = {dmac, BOARD_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, op,
         BOARD_MAC, BOARD_IP, tmac, ip, 144'h0};
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      b = v[479 - 8*i -: 8];
      exp_q.push_back(b);
      crc = crc ^ {24'h0, b};
      for (int k = 0; k < 8; k++) crc = (crc >> 1) ^ (crc[0] ? POLY : 32'h0);
    end
    fcs = ~crc;
    exp_q.push_back(fcs[7:0]);
    exp_q.push_back(fcs[15:8]);
    exp_q.push_back(fcs[23:16]);
    exp_q.push_back(fcs[31:24]);
  endtask

  // monitor
  task automatic monitor();
    bit prev_en;
    int low_run;
    int busy_run;
    bit in_ifg;
    bit seen_frame;
    logic [7:0] e;
    prev_en = 0; low_run = 0; busy_run = 0; in_ifg = 0; seen_frame = 0;
    while (!stim_done) begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 0; mon_run = 0; in_ifg = 0; seen_frame = 0; low_run = 0;
      end else begin
        if (gmii_tx_en) begin
          if (!prev_en) begin
            // the acceptance cycle itself is also idle, hence +1
            if (b2b_mode && seen_frame) chk("ifg_gap", low_run, IFG_BYTES + 1);
            mon_run = 0;
          end
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_byte actual=%h required=no_byte t=%0t", gmii_txd, $time);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("byte%0d", mon_run), {24'h0, gmii_txd}, {24'h0, e});
          end
          chk("busy_in_frame", {31'h0, busy}, 32'h1);
          mon_run++;
        end else begin
          if (prev_en) begin
            chk("frame_len", mon_run, 72);
            chk("done_at_end", {31'h0, tx_done}, 32'h1);
            chk("txd_idle", {24'h0, gmii_txd}, 32'h0);
            in_ifg = 1; busy_run = 0; seen_frame = 1; low_run = 0;
          end else if (tx_done) begin
            chk("stray_done", {31'h0, tx_done}, 32'h0);
          end
          low_run++;
        end
        if (tx_done) done_cnt++;
        if (in_ifg) begin
          if (busy) busy_run++;
          else begin
            chk("ifg_busy_len", busy_run, IFG_BYTES);
            in_ifg = 0;
          end
        end
        prev_en = gmii_tx_en;
      end
    end
  endtask

  // driver tasks
  task automatic wait_not_busy();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic send(input bit typ, input logic [47:0] mac, input logic [31:0] ip);
    wait_not_busy();
    push_frame(typ, mac, ip);
    arp_tx_en   = 1'b1;
    arp_tx_type = typ;
    des_mac     = mac;
    des_ip      = ip;
    @(posedge clk);
    #1;
    chk("accept_tx_en", {31'h0, gmii_tx_en}, 32'h1);
    chk("accept_busy", {31'h0, busy}, 32'h1);
    chk("accept_txd", {24'h0, gmii_txd}, 32'h55);
    @(negedge clk);
    arp_tx_en = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic wait_run(input int bytes);
    int n;
    n = 0;
    while (mon_run < bytes && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mon_run < bytes) chk("run_timeout", mon_run, bytes);
  endtask

  task automatic stimulus();
    int saved;
    // reset state
    #20;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_tx_done", {31'h0, tx_done}, 32'h0);
    chk("rst_tx_en", {31'h0, gmii_tx_en}, 32'h0);
    chk("rst_txd", {24'h0, gmii_txd}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: request; des_mac must be ignored; a pulse and des_ip change during
    //    the frame must neither start a frame nor alter this one
    send(1'b0, 48'h1234_5678_9ABC, 32'hC0A8_0166);
    wait_run(20);
    arp_tx_en   = 1'b1;
    arp_tx_type = 1'b1;
    des_ip      = 32'h0A0B_0C0D;
    @(negedge clk);
    arp_tx_en = 1'b0;
    wait_done(1);

    // 2: reply
    send(1'b1, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0166);
    wait_done(2);

    // 4: back-to-back with arp_tx_en held high; second command fields
    //    change mid-frame and only apply to the next frame
    wait_not_busy();
    push_frame(1'b1, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0166);
    push_frame(1'b0, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0167);
    arp_tx_en   = 1'b1;
    arp_tx_type = 1'b1;
    des_mac     = 48'hA0B1_C2D3_E4F5;
    des_ip      = 32'hC0A8_0166;
    @(posedge clk);
    #1;
    chk("b2b_accept", {31'h0, gmii_tx_en}, 32'h1);
    b2b_mode = 1'b1;
    wait_run(20);
    @(negedge clk);
    arp_tx_type = 1'b0;
    des_ip      = 32'hC0A8_0167;
    wait_done(3);
    wait_done(4);
    arp_tx_en = 1'b0;
    b2b_mode  = 1'b0;

    // 5: reset at byte 30, then a clean frame
    send(1'b0, 48'h0, 32'hC0A8_0166);
    wait_run(30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_en", {31'h0, gmii_tx_en}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_txd", {24'h0, gmii_txd}, 32'h0);
    exp_q.delete();
    saved = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", done_cnt, saved);
    send(1'b1, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0166);
    wait_done(saved + 1);

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    stim_done = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; done_cnt = 0; mon_run = 0;
    b2b_mode = 1'b0; stim_done = 1'b0;
    rst_n = 1'b0; arp_tx_en = 1'b0; arp_tx_type = 1'b0;
    des_mac = 48'h0; des_ip = 32'h0;
    fork
      monitor();
      stimulus();
    join
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
